// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master engine: FSM states, mode
// encodings and wire-order to word-index mapping.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Word index of the k-th bit on the wire for an L-bit character.
  function automatic int unsigned bit_index(input logic lsb_first,
                                            input int unsigned len,
                                            input int unsigned k);
    return lsb_first ? k : (len - 1 - k);
  endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Front-end bus between the register block and the SPI master engine.
// The master modport is the register side, the slave modport the engine.
interface spi_master_core_if #(
  parameter int N   = 8,
  parameter int DW  = 32,
  parameter int NCS = 4
);
  logic                    enable;
  logic                    go;
  logic                    cpol;
  logic                    cpha;
  logic                    lsb_first;
  logic [$clog2(DW)-1:0]   char_len;
  logic [N-1:0]            divider_i;
  logic [$clog2(NCS)-1:0]  cs_sel;
  logic [DW-1:0]           tx_data;
  logic                    busy;
  logic                    done;
  logic [DW-1:0]           rx_data;

  modport master (
    output enable, go, cpol, cpha, lsb_first, char_len, divider_i, cs_sel, tx_data,
    input  busy, done, rx_data
  );

  modport slave (
    input  enable, go, cpol, cpha, lsb_first, char_len, divider_i, cs_sel, tx_data,
    output busy, done, rx_data
  );
endinterface

// File: rtl/spi_sck_div.sv
// SCK half-period generator: toggles sck every divider+1 cycles while run is
// high and flags the cycle before each leading/trailing edge.
module spi_sck_div #(
  parameter int N = 8
) (
  input  logic         sysclk,
  input  logic         rst,
  input  logic         run,
  input  logic [N-1:0] divider,
  input  logic         cpol,
  output logic         sck,
  output logic         lead_edge,
  output logic         trail_edge
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         sck_q, sck_d;
  logic         tc;

  // Strobes fire in the cycle whose closing edge also toggles sck.
  assign tc         = run && (cnt_q == divider);
  assign lead_edge  = tc && (sck_q == cpol);
  assign trail_edge = tc && (sck_q != cpol);
  assign sck        = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run) begin
      cnt_d = '0;
      sck_d = cpol;
    end else if (tc) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + N'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master engine: latches a request, runs SETUP/XFER/HOLD with all four
// CPOL/CPHA modes and returns the received character with a done pulse.
module spi_master_core import spi_pkg::*; #(
  parameter int N   = 8,
  parameter int DW  = 32,
  parameter int NCS = 4
) (
  input  logic              sysclk,
  input  logic              rst,
  spi_master_core_if.slave  bus,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [NCS-1:0]    cs_n
);

  localparam int CW = $clog2(DW);
  localparam int EW = CW + 2;

  spi_state_e     state_q, state_d;
  logic           cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [CW-1:0]  len_q, len_d;
  logic [N-1:0]   div_q, div_d, dly_q, dly_d;
  logic [DW-1:0]  tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [EW-1:0]  edge_q, edge_d;
  logic [CW:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic           mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NCS-1:0] cs_n_q, cs_n_d;

  logic           run, lead_edge, trail_edge, div_cpol, shift_edge, sample_edge;
  logic [1:0]     mode;
  logic [CW:0]    l_val;
  logic [EW-1:0]  two_l;
  logic [CW-1:0]  tx_idx, rx_idx, first_idx;

  // In IDLE the divider follows the live cpol so the idle level tracks it.
  assign run      = (state_q == XFER) && bus.enable;
  assign div_cpol = (state_q == IDLE) ? bus.cpol : cpol_q;

  spi_sck_div #(.N(N)) u_div (
    .sysclk     (sysclk),
    .rst        (rst),
    .run        (run),
    .divider    (div_q),
    .cpol       (div_cpol),
    .sck        (sck),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  assign mode        = {cpol_q, cpha_q};
  assign shift_edge  = ((mode == MODE1) || (mode == MODE3)) ? lead_edge : trail_edge;
  assign sample_edge = ((mode == MODE0) || (mode == MODE2)) ? lead_edge : trail_edge;
  assign l_val       = {1'b0, len_q} + (CW+1)'(1);
  assign two_l       = {l_val, 1'b0};
  assign tx_idx      = CW'(bit_index(lsb_q, 32'(l_val), 32'(tx_bit_q)));
  assign rx_idx      = CW'(bit_index(lsb_q, 32'(l_val), 32'(rx_bit_q)));
  assign first_idx   = CW'(bit_index(bus.lsb_first, 32'(bus.char_len) + 32'd1, 32'd0));

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    len_d     = len_q;
    div_d     = div_q;
    dly_d     = dly_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    tx_bit_d  = tx_bit_q;
    rx_bit_d  = rx_bit_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    case (state_q)
      IDLE: begin
        cs_n_d = '1;
        busy_d = 1'b0;
        if (bus.enable && bus.go) begin
          state_d  = SETUP;
          busy_d   = 1'b1;
          cs_n_d   = ~(NCS'(1) << bus.cs_sel);
          cpol_d   = bus.cpol;
          cpha_d   = bus.cpha;
          lsb_d    = bus.lsb_first;
          len_d    = bus.char_len;
          div_d    = bus.divider_i;
          tx_d     = bus.tx_data;
          dly_d    = '0;
          edge_d   = '0;
          rx_sh_d  = '0;
          rx_bit_d = '0;
          // cpha=0 presents the first bit immediately; cpha=1 waits for the leading edge.
          mosi_d   = bus.cpha ? 1'b0 : bus.tx_data[first_idx];
          tx_bit_d = bus.cpha ? '0 : (CW+1)'(1);
        end
      end
      SETUP: begin
        if (dly_q == div_q) begin
          dly_d   = '0;
          state_d = XFER;
        end else begin
          dly_d = dly_q + N'(1);
        end
      end
      XFER: begin
        if (shift_edge && (tx_bit_q < l_val)) begin
          mosi_d   = tx_q[tx_idx];
          tx_bit_d = tx_bit_q + (CW+1)'(1);
        end
        if (sample_edge) begin
          rx_sh_d[rx_idx] = miso;
          rx_bit_d        = rx_bit_q + (CW+1)'(1);
        end
        if (lead_edge || trail_edge) begin
          edge_d = edge_q + EW'(1);
          if (edge_d == two_l) state_d = HOLD;
        end
      end
      HOLD: begin
        if (dly_q == div_q) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cs_n_d    = '1;
          rx_data_d = rx_sh_q;
        end else begin
          dly_d = dly_q + N'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable abandons the character without touching rx_data.
    if ((state_q != IDLE) && !bus.enable) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      cs_n_d    = '1;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      len_q     <= '0;
      div_q     <= '0;
      dly_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      tx_bit_q  <= '0;
      rx_bit_q  <= '0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      len_q     <= len_d;
      div_q     <= div_d;
      dly_q     <= dly_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      tx_bit_q  <= tx_bit_d;
      rx_bit_q  <= rx_bit_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: directed and random transfers
// against a protocol-level slave model and word-level expectations.
module tb_spi_master_core;

  logic       sysclk;
  logic       rst;
  logic       sck, mosi, miso;
  logic [3:0] cs_n;
  logic       loop_en;
  logic       slv_miso;

  int checks = 0;
  int errors = 0;

  // Monitor / slave model state.
  bit         mon_on = 1'b0;
  bit         cur_cpha;
  int         cur_len, cur_d;
  logic [31:0] slv_wire;
  int         slv_k, edge_n, last_edge, ncyc = 0;
  bit         gap_bad, is_lead;
  logic       prev_sck = 1'b0;
  bit         mosi_bits[$];

  spi_master_core_if #(.N(8), .DW(32), .NCS(4)) bus ();

  spi_master_core #(.N(8), .DW(32), .NCS(4)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus),
    .miso   (miso),
    .sck    (sck),
    .mosi   (mosi),
    .cs_n   (cs_n)
  );

  assign miso = loop_en ? mosi : slv_miso;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wire-order view of a word: bit k is the k-th bit on the line.
  function automatic logic [31:0] wire_word(input logic [31:0] w, input logic lsb, input int len);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[k] = lsb ? w[k] : w[len-1-k];
    return r;
  endfunction

  function automatic logic [31:0] mask_word(input logic [31:0] w, input int len);
    return w & 32'((64'd1 << len) - 64'd1);
  endfunction

  // Slave: watches sck between clock edges, drives miso on shift edges and
  // captures mosi on sample edges.
  always @(negedge sysclk) begin
    ncyc++;
    if (mon_on && (sck !== prev_sck)) begin
      edge_n++;
      if (edge_n > 1 && (ncyc - last_edge) != cur_d) gap_bad = 1'b1;
      last_edge = ncyc;
      is_lead = (edge_n % 2) == 1;
      if (is_lead != cur_cpha) mosi_bits.push_back(mosi);
      else if (slv_k < cur_len) begin
        slv_miso = slv_wire[slv_k];
        slv_k++;
      end
    end
    prev_sck = sck;
  end

  task automatic applyStimulus(input string name, input logic cpol_i, input logic cpha_i,
                               input logic lsb_i, input logic [4:0] len_i, input logic [7:0] div_i,
                               input logic [1:0] sel_i, input logic [31:0] tx_i,
                               input logic [31:0] slv_i, input logic loop_i);
    int len, d, exp_lat, n, lim;
    logic [31:0] exp_rx, got_wire;
    logic [3:0]  exp_cs;
    len     = int'(len_i) + 1;
    d       = int'(div_i) + 1;
    exp_lat = (2*len + 2) * d;
    lim     = exp_lat + 64;
    exp_rx  = mask_word(loop_i ? tx_i : slv_i, len);
    exp_cs  = ~(4'b0001 << sel_i);
    @(posedge sysclk); #1;
    bus.cpol = cpol_i; bus.cpha = cpha_i; bus.lsb_first = lsb_i;
    bus.char_len = len_i; bus.divider_i = div_i; bus.cs_sel = sel_i;
    bus.tx_data = tx_i; bus.go = 1'b0; bus.enable = 1'b1; loop_en = loop_i;
    @(posedge sysclk); #1;
    checkOutput({name, "_idle_sck"}, 64'(sck), 64'(cpol_i));
    cur_cpha = cpha_i; cur_len = len; cur_d = d;
    edge_n = 0; gap_bad = 1'b0; mosi_bits.delete(); prev_sck = sck;
    slv_wire = wire_word(slv_i, lsb_i, len);
    slv_k    = cpha_i ? 0 : 1;
    slv_miso = cpha_i ? 1'b0 : slv_wire[0];
    mon_on   = 1'b1;
    bus.go   = 1'b1;
    @(posedge sysclk); #1;
    bus.go = 1'b0;
    checkOutput({name, "_cs_n_active"}, 64'(cs_n), 64'(exp_cs));
    checkOutput({name, "_busy"}, 64'(bus.busy), 64'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < lim) begin
      @(posedge sysclk); #1;
      n++;
      if (exp_lat > 8 && n == 3) bus.go = 1'b1;
      if (n == 4) bus.go = 1'b0;
    end
    mon_on = 1'b0;
    checkOutput({name, "_latency"}, 64'(n), 64'(exp_lat));
    checkOutput({name, "_rx"}, 64'(bus.rx_data), 64'(exp_rx));
    checkOutput({name, "_cs_n_done"}, 64'(cs_n), 64'hF);
    checkOutput({name, "_busy_done"}, 64'(bus.busy), 64'd0);
    checkOutput({name, "_edges"}, 64'(edge_n), 64'(2*len));
    checkOutput({name, "_gap_bad"}, 64'(gap_bad), 64'd0);
    checkOutput({name, "_mosi_count"}, 64'(mosi_bits.size()), 64'(len));
    got_wire = '0;
    for (int k = 0; k < mosi_bits.size() && k < 32; k++) got_wire[k] = mosi_bits[k];
    checkOutput({name, "_mosi_seq"}, 64'(got_wire), 64'(wire_word(tx_i, lsb_i, len)));
    @(posedge sysclk); #1;
    checkOutput({name, "_no_requeue"}, 64'(bus.busy), 64'd0);
    checkOutput({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    checkOutput({name, "_sck_after"}, 64'(sck), 64'(cpol_i));
  endtask

  task automatic backToBack();
    logic [31:0] tx_cur;
    logic [1:0]  mode;
    int n;
    mode = 2'($urandom_range(0, 3));
    tx_cur = $urandom;
    @(posedge sysclk); #1;
    bus.cpol = mode[1]; bus.cpha = mode[0]; bus.lsb_first = 1'b0;
    bus.char_len = 5'd7; bus.divider_i = 8'd1; bus.cs_sel = 2'd3;
    bus.tx_data = tx_cur; bus.enable = 1'b1; loop_en = 1'b1;
    @(posedge sysclk); #1;
    bus.go = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge sysclk); #1;
      checkOutput($sformatf("b2b%0d_busy", t), 64'(bus.busy), 64'd1);
      checkOutput($sformatf("b2b%0d_cs_n", t), 64'(cs_n), 64'h7);
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
        @(posedge sysclk); #1;
        n++;
      end
      checkOutput($sformatf("b2b%0d_latency", t), 64'(n), 64'd36);
      checkOutput($sformatf("b2b%0d_rx", t), 64'(bus.rx_data), 64'(tx_cur[7:0]));
      checkOutput($sformatf("b2b%0d_cs_n_gap", t), 64'(cs_n), 64'hF);
      tx_cur = $urandom;
      bus.tx_data = tx_cur;
      if (t == 2) bus.go = 1'b0;
    end
    @(posedge sysclk); #1;
    checkOutput("b2b_stop", 64'(bus.busy), 64'd0);
  endtask

  task automatic abortTest();
    logic [31:0] rx_prev;
    logic        prev;
    int cnt, n;
    bit saw_done;
    rx_prev = bus.rx_data;
    @(posedge sysclk); #1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
    bus.char_len = 5'd7; bus.divider_i = 8'd2; bus.cs_sel = 2'd0;
    bus.tx_data = $urandom; bus.enable = 1'b1; loop_en = 1'b1;
    @(posedge sysclk); #1;
    bus.go = 1'b1;
    @(posedge sysclk); #1;
    bus.go = 1'b0;
    prev = sck; cnt = 0; n = 0;
    while (cnt < 5 && n < 200) begin
      @(posedge sysclk); #1;
      n++;
      if (sck !== prev) cnt++;
      prev = sck;
    end
    checkOutput("abort_edge_reached", 64'(cnt), 64'd5);
    bus.enable = 1'b0;
    @(posedge sysclk); #1;
    checkOutput("abort_cs_n", 64'(cs_n), 64'hF);
    checkOutput("abort_sck", 64'(sck), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    saw_done = (bus.done === 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge sysclk); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", 64'(saw_done), 64'd0);
    checkOutput("abort_rx_kept", 64'(bus.rx_data), 64'(rx_prev));
    bus.enable = 1'b1;
  endtask

  task automatic resetMidTransfer();
    @(posedge sysclk); #1;
    bus.cpol = 1'b1; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
    bus.char_len = 5'd7; bus.divider_i = 8'd4; bus.cs_sel = 2'd1;
    bus.tx_data = 32'hFF; bus.enable = 1'b1; loop_en = 1'b1;
    @(posedge sysclk); #1;
    bus.go = 1'b1;
    @(posedge sysclk); #1;
    bus.go = 1'b0;
    repeat (12) @(posedge sysclk);
    #1;
    checkOutput("pre_rst_mosi", 64'(mosi), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_sck", 64'(sck), 64'd0);
    checkOutput("rst_mosi", 64'(mosi), 64'd0);
    checkOutput("rst_cs_n", 64'(cs_n), 64'hF);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_rx", 64'(bus.rx_data), 64'd0);
    repeat (2) @(posedge sysclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; loop_en = 1'b1; slv_miso = 1'b0;
    bus.enable = 1'b0; bus.go = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.lsb_first = 1'b0; bus.char_len = '0; bus.divider_i = '0; bus.cs_sel = '0;
    bus.tx_data = '0;
    #22;
    checkOutput("reset_sck", 64'(sck), 64'd0);
    checkOutput("reset_mosi", 64'(mosi), 64'd0);
    checkOutput("reset_cs_n", 64'(cs_n), 64'hF);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_rx", 64'(bus.rx_data), 64'd0);
    @(posedge sysclk); #1;
    rst = 1'b0;

    applyStimulus("mode0", 1'b0, 1'b0, 1'b0, 5'd7, 8'd4, 2'd2, 32'hA5, 32'h0, 1'b1);
    for (int m = 1; m < 4; m++) begin
      applyStimulus($sformatf("mode%0d", m), m[1], m[0], 1'b1, 5'd15, 8'd2, 2'(m),
                    32'h1234, 32'hBEEF, 1'b0);
    end
    applyStimulus("fastdiv", 1'b0, 1'b0, 1'b0, 5'd31, 8'd0, 2'd0, 32'hDEADBEEF, 32'h0, 1'b1);
    applyStimulus("maxdiv", 1'b1, 1'b1, 1'b0, 5'd7, 8'd255, 2'd1, 32'h3C, 32'h96, 1'b0);
    applyStimulus("len1", 1'b0, 1'b1, 1'b1, 5'd0, 8'd0, 2'd3, 32'h1, 32'h1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 31)), 8'($urandom_range(0, 6)),
                    2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
    end
    backToBack();
    abortTest();
    resetMidTransfer();
    applyStimulus("post_rst", 1'b0, 1'b1, 1'b0, 5'd11, 8'd3, 2'd2, 32'h0ABC, 32'h0F0F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
